// File: rtl/sonar_pkg.sv
// Shared sonar definitions: emitter states, physical constants and the common window length.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BURST,
    BLANK,
    LISTEN,
    COOLDOWN
  } emitter_state_t;

  localparam int unsigned CLK_FREQ_HZ           = 100_000_000;
  localparam int unsigned SPEED_OF_SOUND_CM_S   = 34300;
  localparam int unsigned DEFAULT_LISTEN_WINDOW = 500_000;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // Round-trip echo delay in cycles to one-way range in cm.
  function automatic logic [31:0] cycles_to_cm(input logic [31:0] cycles);
    return 32'((64'(cycles) * 64'(SPEED_OF_SOUND_CM_S)) / (64'd2 * 64'(CLK_FREQ_HZ)));
  endfunction

endpackage

// File: rtl/carrier_gen.sv
// Registered square-wave carrier with complementary leg; both legs low while disabled.
module carrier_gen (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  input  logic [31:0] half_period,
  output logic        wave_out,
  output logic        wave_n_out,
  output logic        half_tick_out
);

  logic [31:0] cnt_q, cnt_d;
  logic        wave_q, wave_d;
  logic        wave_n_q, wave_n_d;
  logic        run_q, run_d;

  // First enabled edge starts on the high half with a fresh half-period count.
  always_comb begin
    cnt_d  = cnt_q;
    wave_d = wave_q;
    run_d  = run_q;
    if (!enable_in) begin
      cnt_d  = half_period - 32'd1;
      wave_d = 1'b0;
      run_d  = 1'b0;
    end else if (!run_q) begin
      cnt_d  = half_period - 32'd1;
      wave_d = 1'b1;
      run_d  = 1'b1;
    end else if (cnt_q == 32'd0) begin
      cnt_d  = half_period - 32'd1;
      wave_d = ~wave_q;
    end else begin
      cnt_d = cnt_q - 32'd1;
    end
    wave_n_d = run_d & ~wave_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q    <= half_period - 32'd1;
      wave_q   <= 1'b0;
      wave_n_q <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wave_q   <= wave_d;
      wave_n_q <= wave_n_d;
      run_q    <= run_d;
    end
  end

  assign wave_out      = wave_q;
  assign wave_n_out    = wave_n_q;
  assign half_tick_out = run_q && (cnt_q == 32'd0);

endmodule

// File: rtl/burst_emitter.sv
// Sonar transmit sequencer: carrier burst, blanking, listen window, cooldown.
// IDLE: wait trigger | BURST: drive carrier | BLANK: ring-down | LISTEN: echo valid | COOLDOWN: ping spacing
module burst_emitter
  import sonar_pkg::*;
#(
  parameter int unsigned CARRIER_HALF_PERIOD = 1250,
  parameter int unsigned NUM_PULSES          = 8,
  parameter int unsigned BLANK_CYCLES        = 50000,
  parameter int unsigned LISTEN_WINDOW       = DEFAULT_LISTEN_WINDOW,
  parameter int unsigned COOLDOWN_CYCLES     = 100000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        trigger_in,
  input  logic        stop_in,
  output logic        tx_p_out,
  output logic        tx_n_out,
  output logic [31:0] time_since_emission,
  output logic        listen_out,
  output logic        window_done_out,
  output logic        busy_out
);

  if (CARRIER_HALF_PERIOD < 1 || NUM_PULSES < 1 || COOLDOWN_CYCLES < 1) begin : g_bad_basic
    $fatal(1, "burst_emitter: half period, pulse count and cooldown must be nonzero");
  end
  if (BLANK_CYCLES < 2 * NUM_PULSES * CARRIER_HALF_PERIOD) begin : g_bad_blank
    $fatal(1, "burst_emitter: BLANK_CYCLES shorter than the burst");
  end
  if (LISTEN_WINDOW <= BLANK_CYCLES) begin : g_bad_window
    $fatal(1, "burst_emitter: LISTEN_WINDOW must exceed BLANK_CYCLES");
  end

  emitter_state_t state_q, state_d;
  logic [31:0]    tse_q, tse_d;
  logic [31:0]    half_cnt_q, half_cnt_d;
  logic [31:0]    cool_cnt_q, cool_cnt_d;
  logic           listen_q, listen_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           half_tick;

  carrier_gen u_carrier (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .enable_in     (state_d == BURST),
    .half_period   (CARRIER_HALF_PERIOD),
    .wave_out      (tx_p_out),
    .wave_n_out    (tx_n_out),
    .half_tick_out (half_tick)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      tse_q      <= '0;
      half_cnt_q <= '0;
      cool_cnt_q <= '0;
      listen_q   <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tse_q      <= tse_d;
      half_cnt_q <= half_cnt_d;
      cool_cnt_q <= cool_cnt_d;
      listen_q   <= listen_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (trigger_in) state_d = BURST;
      BURST:    if (half_tick && half_cnt_q == 32'd0) state_d = BLANK;
      BLANK:    if (tse_q >= BLANK_CYCLES - 1) state_d = LISTEN;
      LISTEN:   if (stop_in || tse_q >= LISTEN_WINDOW - 1) state_d = COOLDOWN;
      COOLDOWN: if (cool_cnt_q == 32'd0) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Count is zero throughout IDLE and on the first BURST cycle; frozen in COOLDOWN.
  always_comb begin
    tse_d      = tse_q;
    half_cnt_d = half_cnt_q;
    cool_cnt_d = cool_cnt_q;
    if (state_q == IDLE || state_d == IDLE) begin
      tse_d = '0;
    end else if (state_q != COOLDOWN) begin
      tse_d = sat_inc(tse_q);
    end
    if (state_q != BURST) begin
      half_cnt_d = 2 * NUM_PULSES - 1;
    end else if (half_tick && half_cnt_q != 32'd0) begin
      half_cnt_d = half_cnt_q - 32'd1;
    end
    if (state_q != COOLDOWN) begin
      cool_cnt_d = COOLDOWN_CYCLES - 1;
    end else if (cool_cnt_q != 32'd0) begin
      cool_cnt_d = cool_cnt_q - 32'd1;
    end
    listen_d = (state_d == LISTEN);
    done_d   = (state_q == LISTEN) && (state_d == COOLDOWN);
    busy_d   = (state_d != IDLE);
  end

  assign time_since_emission = tse_q;
  assign listen_out          = listen_q;
  assign window_done_out     = done_q;
  assign busy_out            = busy_q;

endmodule

// File: doc/burst_emitter.md
Name: burst_emitter

Overview:
- Transmit end of the sonar ranging path. On trigger it drives an N-cycle ultrasonic carrier burst onto the transducer driver.
- After the burst it holds a blanking interval, then opens a listen window. Through both, it publishes the time_since_emission cycle count that the echo/range logic consumes.
- After the window closes, a cooldown enforces a minimum ping spacing before the next trigger is accepted.

Parameters:
- CARRIER_HALF_PERIOD, 1250, clock cycles per carrier half-period (40 kHz at 100 MHz).
- NUM_PULSES, 8, full carrier periods per burst.
- BLANK_CYCLES, 50000, cycles from emission start before listening opens (ring-down suppression); must be >= 2*NUM_PULSES*CARRIER_HALF_PERIOD.
- LISTEN_WINDOW, 500000, cycles from emission start at which the window closes; must be > BLANK_CYCLES.
- COOLDOWN_CYCLES, 100000, idle cycles enforced after the window closes.

Ports:
- clk_in  input  1  100 MHz system clock
- rst_in  input  1  synchronous, active-high reset
- trigger_in  input  1  single-cycle ping request
- stop_in  input  1  early window termination (echo accepted downstream)
- tx_p_out  output  1  transducer drive, positive leg
- tx_n_out  output  1  transducer drive, negative leg
- time_since_emission  output  32  cycles since the first burst cycle
- listen_out  output  1  high while echoes are valid to detect
- window_done_out  output  1  one-cycle pulse when the listen phase ends
- busy_out  output  1  high in every state except IDLE

Behaviour:
- Clocking and reset: one clock, clk_in. rst_in is synchronous and active-high.
- Reset values: state IDLE; tx_p_out=0, tx_n_out=0, time_since_emission=0, listen_out=0, window_done_out=0, busy_out=0. All outputs are registered.
- Reset mid-operation: reset in any state returns to IDLE at the next edge, with both tx legs low.
- States: IDLE, BURST, BLANK, LISTEN, COOLDOWN.
- IDLE:
  - Both tx legs are low (undriven, not complementary). time_since_emission holds 0.
  - If trigger_in=1 at edge k, the state is BURST from edge k+1, with tx_p_out=1, tx_n_out=0 and time_since_emission=0.
- Trigger outside IDLE: ignored, including the last COOLDOWN cycle. No queuing.
- BURST:
  - tx_p_out toggles every CARRIER_HALF_PERIOD cycles, with tx_n_out = ~tx_p_out.
  - After 2*NUM_PULSES half-periods the state moves to BLANK and both legs go low.
  - The burst ends on a low half, so the last high is followed by CARRIER_HALF_PERIOD low-driven cycles (tx_n_out=1) before both legs go low.
- time_since_emission:
  - Increments by 1 every cycle in BURST, BLANK and LISTEN, and saturates at 2^32-1.
  - Holds its value in COOLDOWN. Clears on entering BURST.
- BLANK: when time_since_emission == BLANK_CYCLES-1, the next state is LISTEN, so listen_out rises in the cycle where the count reads BLANK_CYCLES.
- LISTEN:
  - listen_out=1.
  - Normal close: if time_since_emission == LISTEN_WINDOW-1, the next cycle is COOLDOWN with listen_out=0 and window_done_out=1 for exactly one cycle.
  - Early close: stop_in=1 has the same effect immediately (next cycle COOLDOWN plus the pulse); the count freezes at its value+1.
  - Simultaneous stop_in and window expiry: a single done pulse, identical result.
- stop_in outside LISTEN: ignored.
- COOLDOWN: counts COOLDOWN_CYCLES cycles (separate counter), then returns to IDLE. busy_out falls in the first IDLE cycle.
- Elaboration checks: a parameter-constraint violation raises a fatal assertion.

Decomposition:
- sonar_pkg holds:
  - the emitter_state_t enum {IDLE, BURST, BLANK, LISTEN, COOLDOWN};
  - CLK_FREQ_HZ = 100_000_000;
  - SPEED_OF_SOUND_CM_S = 34300;
  - the shared default window length, so the emitter and the range calculator agree.
- One sub-module: carrier_gen. It takes enable_in and half_period, and produces a square wave plus a half_tick strobe. The FSM counts half_ticks to end BURST.

Test Plan (scaled: HALF=4, NUM_PULSES=2, BLANK=20, WINDOW=50, COOLDOWN=10):
- Burst shape: trigger at edge k -> tx_p_out pattern 1111 0000 1111 0000 from edge k+1, tx_n_out the inverse, then both legs 0 from edge k+17; time_since_emission reads 0 at k+1 and 16 at k+17.
- Window timing: the same trigger -> listen_out is 1 exactly while time_since_emission is 20..49; window_done_out is a single pulse in the cycle after count 49; the count then holds 50; busy_out falls 10 cycles later.
- Early stop: stop_in asserted when the count reads 30 -> next cycle listen_out=0, window_done_out=1, count frozen at 31, COOLDOWN entered.
- Trigger rejection: trigger during BURST, during LISTEN, and on the last COOLDOWN cycle -> all ignored with no disturbance; trigger on the first IDLE cycle -> accepted, count restarts at 0.
- Reset mid-burst: rst_in high while tx_p_out=1 -> next edge tx_p_out=tx_n_out=0, busy_out=0, count=0; the next trigger produces a full clean burst.
- stop_in while in BLANK -> ignored; listen_out still rises at count 20.
